// File: rtl/ps2_scancode_decoder_if.sv
// Connection bundle between the PS/2 receiver FIFO, the scan-code decoder and its consumer.
// master = decoder side, slave = FIFO/consumer side.
interface ps2_scancode_decoder_if;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_rdn;
  logic       key_valid;
  logic       key_ack;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic [7:0] key_ascii;
  logic       shift_on;
  logic       ctrl_on;
  logic       caps_on;

  modport master (
    input  kbd_data, kbd_ready, key_ack,
    output kbd_rdn, key_valid, key_code, key_ext, key_break, key_ascii,
           shift_on, ctrl_on, caps_on
  );

  modport slave (
    output kbd_data, kbd_ready, key_ack,
    input  kbd_rdn, key_valid, key_code, key_ext, key_break, key_ascii,
           shift_on, ctrl_on, caps_on
  );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Drains PS/2 set-2 scan-code bytes from the receiver FIFO, tracks modifiers and
// presents one decoded key event at a time through a valid/ack holding register.
module ps2_scancode_decoder #(
  parameter int PAUSE_SKIP = 7
) (
  input  logic clk,
  input  logic clrn,
  ps2_scancode_decoder_if.master bus
);
  localparam int SKIP_W = $clog2(PAUSE_SKIP + 1);

  typedef enum logic {IDLE, DECODE} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        byte_reg, byte_next;
  logic              ext_pend_reg, ext_pend_next;
  logic              brk_pend_reg, brk_pend_next;
  logic [SKIP_W-1:0] skip_reg, skip_next;
  logic              lshift_reg, lshift_next, rshift_reg, rshift_next;
  logic              lctrl_reg, lctrl_next, rctrl_reg, rctrl_next;
  logic              caps_reg, caps_next, caps_held_reg, caps_held_next;
  logic              key_valid_reg, key_valid_next;
  logic [7:0]        key_code_reg, key_code_next;
  logic              key_ext_reg, key_ext_next;
  logic              key_break_reg, key_break_next;
  logic [7:0]        key_ascii_reg, key_ascii_next;
  logic              pop;
  logic              shift_on, ctrl_on;

  assign shift_on = lshift_reg | rshift_reg;
  assign ctrl_on  = lctrl_reg | rctrl_reg;

  function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                          input logic shift, input logic ctrl,
                                          input logic caps);
    logic [4:0] letter;
    logic [7:0] res;
    letter = 5'd0;
    res    = 8'h00;
    if (ext) begin
      if (code == 8'h5A)      res = 8'h0D;
      else if (code == 8'h4A) res = 8'h2F;
    end else begin
      case (code)
        8'h1C: letter = 5'd1;   8'h32: letter = 5'd2;   8'h21: letter = 5'd3;
        8'h23: letter = 5'd4;   8'h24: letter = 5'd5;   8'h2B: letter = 5'd6;
        8'h34: letter = 5'd7;   8'h33: letter = 5'd8;   8'h43: letter = 5'd9;
        8'h3B: letter = 5'd10;  8'h42: letter = 5'd11;  8'h4B: letter = 5'd12;
        8'h3A: letter = 5'd13;  8'h31: letter = 5'd14;  8'h44: letter = 5'd15;
        8'h4D: letter = 5'd16;  8'h15: letter = 5'd17;  8'h2D: letter = 5'd18;
        8'h1B: letter = 5'd19;  8'h2C: letter = 5'd20;  8'h3C: letter = 5'd21;
        8'h2A: letter = 5'd22;  8'h1D: letter = 5'd23;  8'h22: letter = 5'd24;
        8'h35: letter = 5'd25;  8'h1A: letter = 5'd26;
        default: letter = 5'd0;
      endcase
      if (letter != 5'd0) begin
        // Ctrl yields the control code for the letter regardless of case.
        if (ctrl)              res = {3'b000, letter};
        else if (shift ^ caps) res = 8'h40 + {3'b000, letter};
        else                   res = 8'h60 + {3'b000, letter};
      end else begin
        case (code)
          8'h45: res = shift ? 8'h29 : 8'h30;
          8'h16: res = shift ? 8'h21 : 8'h31;
          8'h1E: res = shift ? 8'h40 : 8'h32;
          8'h26: res = shift ? 8'h23 : 8'h33;
          8'h25: res = shift ? 8'h24 : 8'h34;
          8'h2E: res = shift ? 8'h25 : 8'h35;
          8'h36: res = shift ? 8'h5E : 8'h36;
          8'h3D: res = shift ? 8'h26 : 8'h37;
          8'h3E: res = shift ? 8'h2A : 8'h38;
          8'h46: res = shift ? 8'h28 : 8'h39;
          8'h29: res = 8'h20;
          8'h5A: res = 8'h0D;
          8'h66: res = 8'h08;
          8'h76: res = 8'h1B;
          8'h0D: res = 8'h09;
          default: res = 8'h00;
        endcase
      end
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg     <= IDLE;
      byte_reg      <= 8'h00;
      ext_pend_reg  <= 1'b0;
      brk_pend_reg  <= 1'b0;
      skip_reg      <= '0;
      lshift_reg    <= 1'b0;
      rshift_reg    <= 1'b0;
      lctrl_reg     <= 1'b0;
      rctrl_reg     <= 1'b0;
      caps_reg      <= 1'b0;
      caps_held_reg <= 1'b0;
      key_valid_reg <= 1'b0;
      key_code_reg  <= 8'h00;
      key_ext_reg   <= 1'b0;
      key_break_reg <= 1'b0;
      key_ascii_reg <= 8'h00;
    end else begin
      state_reg     <= state_next;
      byte_reg      <= byte_next;
      ext_pend_reg  <= ext_pend_next;
      brk_pend_reg  <= brk_pend_next;
      skip_reg      <= skip_next;
      lshift_reg    <= lshift_next;
      rshift_reg    <= rshift_next;
      lctrl_reg     <= lctrl_next;
      rctrl_reg     <= rctrl_next;
      caps_reg      <= caps_next;
      caps_held_reg <= caps_held_next;
      key_valid_reg <= key_valid_next;
      key_code_reg  <= key_code_next;
      key_ext_reg   <= key_ext_next;
      key_break_reg <= key_break_next;
      key_ascii_reg <= key_ascii_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    byte_next      = byte_reg;
    ext_pend_next  = ext_pend_reg;
    brk_pend_next  = brk_pend_reg;
    skip_next      = skip_reg;
    lshift_next    = lshift_reg;
    rshift_next    = rshift_reg;
    lctrl_next     = lctrl_reg;
    rctrl_next     = rctrl_reg;
    caps_next      = caps_reg;
    caps_held_next = caps_held_reg;
    key_valid_next = key_valid_reg;
    key_code_next  = key_code_reg;
    key_ext_next   = key_ext_reg;
    key_break_next = key_break_reg;
    key_ascii_next = key_ascii_reg;
    pop            = 1'b0;

    // An ack retires the event; a load later in this block takes precedence.
    if (key_valid_reg && bus.key_ack) key_valid_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.kbd_ready && (!key_valid_reg || bus.key_ack)) begin
          pop        = 1'b1;
          byte_next  = bus.kbd_data;
          state_next = DECODE;
        end
      end
      DECODE: begin
        state_next = IDLE;
        if (skip_reg != '0) begin
          skip_next = skip_reg - SKIP_W'(1);
        end else if (byte_reg == 8'hE1) begin
          skip_next     = SKIP_W'(PAUSE_SKIP);
          ext_pend_next = 1'b0;
          brk_pend_next = 1'b0;
        end else if (byte_reg == 8'hE0) begin
          ext_pend_next = 1'b1;
        end else if (byte_reg == 8'hF0) begin
          brk_pend_next = 1'b1;
        end else if (byte_reg inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF}) begin
          ext_pend_next = 1'b0;
          brk_pend_next = 1'b0;
        end else begin
          ext_pend_next = 1'b0;
          brk_pend_next = 1'b0;
          if (!ext_pend_reg && byte_reg == 8'h12) begin
            lshift_next = !brk_pend_reg;
          end else if (!ext_pend_reg && byte_reg == 8'h59) begin
            rshift_next = !brk_pend_reg;
          end else if (byte_reg == 8'h14) begin
            if (ext_pend_reg) rctrl_next = !brk_pend_reg;
            else              lctrl_next = !brk_pend_reg;
          end else if (!ext_pend_reg && byte_reg == 8'h58) begin
            // Only the first make toggles; typematic repeats keep caps_held set.
            if (!brk_pend_reg && !caps_held_reg) caps_next = !caps_reg;
            caps_held_next = !brk_pend_reg;
          end else begin
            key_valid_next = 1'b1;
            key_code_next  = byte_reg;
            key_ext_next   = ext_pend_reg;
            key_break_next = brk_pend_reg;
            key_ascii_next = ascii_of(byte_reg, ext_pend_reg, shift_on, ctrl_on, caps_reg);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.kbd_rdn   = !(pop && clrn);
  assign bus.key_valid = key_valid_reg;
  assign bus.key_code  = key_code_reg;
  assign bus.key_ext   = key_ext_reg;
  assign bus.key_break = key_break_reg;
  assign bus.key_ascii = key_ascii_reg;
  assign bus.shift_on  = shift_on;
  assign bus.ctrl_on   = ctrl_on;
  assign bus.caps_on   = caps_reg;
endmodule
